// File: rtl/ble6_cfg_pkg.sv
// Shared types and constants for the BLE6 configuration writer.
package ble6_cfg_pkg;

   // Writer FSM states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_SETUP = 3'd2,
      ST_PULSE = 3'd3,
      ST_HOLD  = 3'd4,
      ST_DONE  = 3'd5
   } cfg_wr_state_t;

   localparam int unsigned BLE6_NUM_CELLS = 66;
   localparam int unsigned BLE6_LUT_CELLS = 64;
   localparam int unsigned CFG_PULSE_CNT_W = 4;

   // Number of bitstream words needed to cover all cells (ceil division)
   function automatic int unsigned cfg_num_words(input int unsigned cells, input int unsigned data_w);
      return (cells + data_w - 1) / data_w;
   endfunction

endpackage

// File: rtl/ble6_cfg_writer_dec.sv
// Index to one-hot decoder with enable; bit 0 of the output is cell 0.
module cfg_onehot_dec #(
   parameter int unsigned N     = 66,
   parameter int unsigned IDX_W = 7
) (
   input  logic [IDX_W-1:0] idx,
   input  logic             en,
   output logic [0:N-1]     onehot_c
);

   // Combinational one-hot select of cell idx when enabled
   always_comb begin
      onehot_c = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (en && (idx == IDX_W'(i))) begin
            onehot_c[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ble6_cfg_writer.sv
// Streams a packed bitstream into the bl/wl memory port of one BLE6,
// one cell at a time: set bl, pulse wl, hold bl, advance.
module ble6_cfg_writer
   import ble6_cfg_pkg::*;
#(
   parameter int unsigned NUM_CELLS = BLE6_NUM_CELLS,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned WL_PULSE  = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [DATA_W-1:0]   cfg_data,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   output logic [0:NUM_CELLS-1] bl,
   output logic [0:NUM_CELLS-1] wl,
   output logic                busy,
   output logic                done
);

   localparam int unsigned IDX_W = $clog2(NUM_CELLS);
   localparam int unsigned BP_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   cfg_wr_state_t              state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [BP_W-1:0]            bp_q, bp_d;
   logic [DATA_W-1:0]          word_q, word_d;
   logic [CFG_PULSE_CNT_W-1:0] cnt_q, cnt_d;

   logic                       cell_active;
   logic                       wl_en;
   logic                       cell_bit;
   logic [0:NUM_CELLS-1]       wl_d;
   logic [0:NUM_CELLS-1]       bl_d;

   // Next-state, datapath and next-output logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      bp_d    = bp_q;
      word_d  = word_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FETCH;
               idx_d   = '0;
            end
         end
         ST_FETCH: begin
            // cfg_ready is high for the whole FETCH state
            if (cfg_valid) begin
               word_d  = cfg_data;
               bp_d    = '0;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_d = ST_PULSE;
            cnt_d   = CFG_PULSE_CNT_W'(WL_PULSE - 1);
         end
         ST_PULSE: begin
            if (cnt_q == '0) begin
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q - CFG_PULSE_CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (idx_q == IDX_W'(NUM_CELLS - 1)) begin
               state_d = ST_DONE;
            end else if (bp_q == BP_W'(DATA_W - 1)) begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = ST_FETCH;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               bp_d    = bp_q + BP_W'(1);
               state_d = ST_SETUP;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are computed from the next state so the registers line up with it
      cell_active = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD);
      wl_en       = (state_d == ST_PULSE);
      cell_bit    = word_d[bp_d];
   end

   // Word-line strobe decoder
   cfg_onehot_dec #(
      .N     (NUM_CELLS),
      .IDX_W (IDX_W)
   ) u_wl_dec (
      .idx      (idx_d),
      .en       (wl_en),
      .onehot_c (wl_d)
   );

   // Bit-line select mask; only the active cell may carry a 1
   cfg_onehot_dec #(
      .N     (NUM_CELLS),
      .IDX_W (IDX_W)
   ) u_bl_dec (
      .idx      (idx_d),
      .en       (cell_active && cell_bit),
      .onehot_c (bl_d)
   );

   // State, datapath and registered outputs with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         bp_q      <= '0;
         word_q    <= '0;
         cnt_q     <= '0;
         cfg_ready <= 1'b0;
         bl        <= '0;
         wl        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         bp_q      <= bp_d;
         word_q    <= word_d;
         cnt_q     <= cnt_d;
         cfg_ready <= (state_d == ST_FETCH);
         bl        <= bl_d;
         wl        <= wl_d;
         busy      <= (state_d != ST_IDLE);
         done      <= (state_d == ST_DONE);
      end
   end

endmodule

// File: tb/tb_ble6_cfg_writer.sv
// Directed bench for ble6_cfg_writer (default instance plus a WL_PULSE=1 instance).
module tb_ble6_cfg_writer;
   import ble6_cfg_pkg::*;

   localparam int unsigned N = 66;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         cfg_valid = 1'b0;
   logic [7:0]   cfg_data;
   logic         cfg_ready0, busy0, done0;
   logic         cfg_ready1, busy1, done1;
   logic [0:N-1] bl0, wl0, bl1, wl1;

   int checks = 0;
   int errors = 0;

   logic [7:0]   feed [0:15];
   int           hs = 0;
   logic [3:0]   hs_idx;
   logic [0:N-1] mem, wmask;
   logic         clr_mem = 1'b0;
   logic [0:N-1] pw1, pb1;
   logic         pr = 1'b0;

   assign hs_idx   = hs[3:0];
   assign cfg_data = feed[hs_idx];

   always #5 clk = ~clk;

   ble6_cfg_writer #(.NUM_CELLS(N), .DATA_W(8), .WL_PULSE(2)) u_dut0 (
      .clk(clk), .reset(reset), .start(start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready0), .bl(bl0), .wl(wl0), .busy(busy0), .done(done0));

   ble6_cfg_writer #(.NUM_CELLS(N), .DATA_W(8), .WL_PULSE(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready1), .bl(bl1), .wl(wl1), .busy(busy1), .done(done1));

   // Handshake counter, cell memory model and protocol monitors
   always @(posedge clk) begin
      if (!reset) hs <= 0;
      else if (cfg_valid && cfg_ready0) hs <= hs + 1;

      if (clr_mem) wmask <= '0;
      else begin
         for (int i = 0; i < N; i++) begin
            if (wl0[i] === 1'b1) begin
               mem[i]   <= bl0[i];
               wmask[i] <= 1'b1;
            end
         end
      end

      if (pr) begin
         checks++;
         assert ($countones(wl0) <= 1) else begin errors++; $error("FAIL wl0_onehot observed=%0h expected=at_most_one", wl0); end
         checks++;
         assert ($countones(wl1) <= 1) else begin errors++; $error("FAIL wl1_onehot observed=%0h expected=at_most_one", wl1); end
         checks++;
         assert ($countones(bl1) <= 1) else begin errors++; $error("FAIL bl1_single observed=%0h expected=at_most_one", bl1); end
         if (pw1 === '0 && wl1 !== '0) begin
            checks++;
            assert (bl1 === pb1) else begin errors++; $error("FAIL bl1_rise_stable observed=%0h expected=%0h", bl1, pb1); end
         end
         if (pw1 !== '0 && wl1 === '0) begin
            checks++;
            assert (bl1 === pb1) else begin errors++; $error("FAIL bl1_fall_stable observed=%0h expected=%0h", bl1, pb1); end
         end
      end
      pw1 <= wl1;
      pb1 <= bl1;
      pr  <= reset;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full pass with cfg_valid high; optional stall before word 3 and a start poke while busy
   task automatic run_pass(input int stall_len, input bit poke_start, output int n);
      bit stalled;
      stalled   = 1'b0;
      cfg_valid = 1'b1;
      start     = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      while (done0 !== 1'b1 && n < 600) begin
         if (stall_len > 0 && !stalled && cfg_ready0 === 1'b1 && hs == 3) begin
            cfg_valid = 1'b0;
            for (int k = 0; k < stall_len; k++) begin
               tick();
               n++;
               chk("stall_wl_low", 128'(wl0), 128'(0));
            end
            cfg_valid = 1'b1;
            stalled   = 1'b1;
         end else begin
            if (poke_start && n == 100) start = 1'b1;
            tick();
            start = 1'b0;
            n++;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [0:N-1] e;
      int n;
      int k;

      for (int i = 0; i < 16; i++) feed[i] = 8'h00;
      chk("num_words", 128'(cfg_num_words(66, 8)), 128'(9));

      // Reset / idle
      reset = 1'b0; start = 1'b0; cfg_valid = 1'b1;
      repeat (3) tick();
      chk("rst_busy", 128'(busy0), 128'(0));
      chk("rst_wl", 128'(wl0), 128'(0));
      reset = 1'b1;
      tick();
      chk("idle_bl", 128'(bl0), 128'(0));
      chk("idle_wl", 128'(wl0), 128'(0));
      chk("idle_ready", 128'(cfg_ready0), 128'(0));
      chk("idle_busy", 128'(busy0), 128'(0));
      chk("idle_done", 128'(done0), 128'(0));
      tick();
      chk("idle_ready_valid", 128'(cfg_ready0), 128'(0));

      // First cell with word 0xA5
      feed[0] = 8'hA5;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("fetch_ready", 128'(cfg_ready0), 128'(1));
      chk("fetch_busy", 128'(busy0), 128'(1));
      e = '0; e[0] = 1'b1;
      tick();
      chk("setup0_bl", 128'(bl0), 128'(e));
      chk("setup0_wl", 128'(wl0), 128'(0));
      chk("setup0_ready", 128'(cfg_ready0), 128'(0));
      tick();
      chk("pulse0a_wl", 128'(wl0), 128'(e));
      chk("pulse0a_bl", 128'(bl0), 128'(e));
      tick();
      chk("pulse0b_wl", 128'(wl0), 128'(e));
      tick();
      chk("hold0_wl", 128'(wl0), 128'(0));
      chk("hold0_bl", 128'(bl0), 128'(e));
      tick();
      chk("setup1_bl", 128'(bl0), 128'(0));
      chk("setup1_wl", 128'(wl0), 128'(0));
      tick();
      e = '0; e[1] = 1'b1;
      chk("pulse1_wl", 128'(wl0), 128'(e));
      chk("pulse1_bl", 128'(bl0), 128'(0));
      chk("first_hs", 128'(hs), 128'(1));
      reset = 1'b0; tick(); reset = 1'b1; tick();

      // Full pass: 0xFF x8 then 0x01, start poked while busy
      for (int i = 0; i < 8; i++) feed[i] = 8'hFF;
      feed[8] = 8'h01;
      for (int i = 9; i < 16; i++) feed[i] = 8'hAA;
      clr_mem = 1'b1; tick(); clr_mem = 1'b0;
      run_pass(0, 1'b1, n);
      chk("full_len", 128'(n), 128'(274));
      chk("full_done", 128'(done0), 128'(1));
      chk("full_hs", 128'(hs), 128'(9));
      e = '1; e[65] = 1'b0;
      chk("full_mem", 128'(mem), 128'(e));
      chk("full_written", 128'(wmask), 128'({N{1'b1}}));
      tick();
      chk("after_done", 128'(done0), 128'(0));
      chk("after_busy", 128'(busy0), 128'(0));
      chk("after_ready", 128'(cfg_ready0), 128'(0));
      chk("p1_idle", 128'(busy1), 128'(0));

      // Stall of 5 cycles before word 3
      reset = 1'b0; tick(); reset = 1'b1; tick();
      run_pass(5, 1'b0, n);
      chk("stall_len", 128'(n), 128'(279));
      chk("stall_hs", 128'(hs), 128'(9));
      tick();

      // Reset while wl[17] is high, then restart from cell 0
      reset = 1'b0; tick(); reset = 1'b1; tick();
      cfg_valid = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      k = 0;
      while (wl0[17] !== 1'b1 && k < 300) begin tick(); k++; end
      chk("wl17_seen", 128'(wl0[17]), 128'(1));
      reset = 1'b0;
      tick();
      chk("midrst_wl", 128'(wl0), 128'(0));
      chk("midrst_bl", 128'(bl0), 128'(0));
      chk("midrst_busy", 128'(busy0), 128'(0));
      chk("midrst_ready", 128'(cfg_ready0), 128'(0));
      reset = 1'b1;
      tick();
      start = 1'b1; tick(); start = 1'b0;
      chk("restart_ready", 128'(cfg_ready0), 128'(1));
      e = '0; e[0] = 1'b1;
      tick();
      chk("restart_bl", 128'(bl0), 128'(e));
      tick();
      chk("restart_wl", 128'(wl0), 128'(e));
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
